relu_pool_engine: RTL

Parametrised successor to the fixed 32x32 ReLU + 2x2 max-pool stage. Accepts one raster-order feature map per start_signal, applies optional ReLU, then 2x2 stride-2 pooling in max or average mode. Uses a half-width row buffer instead of storing the frame. Sits between the conv accumulator output and the next layer's input stream.

---
 rtl/relu_pool_engine.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/relu_pool_engine.sv
// ReLU + 2x2 stride-2 pooling (max or average) over a raster-order feature map,
// using a half-width row buffer. Define RELU_POOL_LEAKY_EN for leaky ReLU (x >>> 3).
module relu_pool_engine #(
    parameter int DATA_W = 22,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_signal,
    input  logic                     pool_mode,
    input  logic                     relu_bypass,
    input  logic                     pixel_valid,
    input  logic signed [DATA_W-1:0] pixel_in,
    output logic signed [DATA_W-1:0] result_out,
    output logic                     result_valid,
    output logic                     done_signal,
    output logic                     busy
);

    localparam int OUT_W = IMG_W / 2;
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int BW    = DATA_W + 2;
    localparam int BAW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [XW-1:0]           x_q, x_d;
    logic [YW-1:0]           y_q, y_d;
    logic                    mode_q, mode_d;
    logic                    bypass_q, bypass_d;
    logic signed [BW-1:0]    pair_q, pair_d;
    logic signed [DATA_W-1:0] result_q, result_d;
    logic                    rv_q, rv_d;
    logic                    done_q, done_d;

    // Holds the combined even-row pair per output column, widened so an average-mode sum never overflows
    logic signed [BW-1:0]    row_buf [OUT_W];
    logic                    buf_we;
    logic [BAW-1:0]          buf_addr;
    logic signed [BW-1:0]    buf_wdata;
    logic signed [BW-1:0]    buf_rd;

    logic signed [DATA_W-1:0] relu_px;
    logic signed [BW-1:0]    px_ext;
    logic signed [BW-1:0]    pair_max;
    logic signed [BW-1:0]    pair_sum;
    logic signed [BW-1:0]    quad_max;
    logic signed [BW-1:0]    quad_sum;
    logic                    last_px;

    always_comb begin
        relu_px = pixel_in;
        if (!bypass_q && pixel_in[DATA_W-1]) begin
`ifdef RELU_POOL_LEAKY_EN
            relu_px = pixel_in >>> 3;
`else
            relu_px = '0;
`endif
        end
    end

    assign px_ext   = {{2{relu_px[DATA_W-1]}}, relu_px};
    assign buf_addr = BAW'(x_q >> 1);
    assign buf_rd   = row_buf[buf_addr];
    assign pair_max = (pair_q > px_ext) ? pair_q : px_ext;
    assign pair_sum = pair_q + px_ext;
    assign quad_max = (buf_rd > pair_max) ? buf_rd : pair_max;
    assign quad_sum = buf_rd + pair_sum;
    assign last_px  = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        mode_d    = mode_q;
        bypass_d  = bypass_q;
        pair_d    = pair_q;
        result_d  = result_q;
        rv_d      = 1'b0;
        done_d    = 1'b0;
        buf_we    = 1'b0;
        buf_wdata = mode_q ? pair_sum : pair_max;
        case (state_q)
            S_IDLE: begin
                if (start_signal) begin
                    state_d  = S_RUN;
                    mode_d   = pool_mode;
                    bypass_d = relu_bypass;
                    x_d      = '0;
                    y_d      = '0;
                end
            end
            S_RUN: begin
                if (pixel_valid) begin
                    if (!x_q[0]) begin
                        pair_d = px_ext;
                    end else if (!y_q[0]) begin
                        buf_we = 1'b1;
                    end else begin
                        rv_d     = 1'b1;
                        result_d = mode_q ? DATA_W'(quad_sum >>> 2) : DATA_W'(quad_max);
                    end
                    if (x_q == XW'(IMG_W - 1)) begin
                        x_d = '0;
                        y_d = (y_q == YW'(IMG_H - 1)) ? '0 : y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                    if (last_px) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            mode_q   <= 1'b0;
            bypass_q <= 1'b0;
            pair_q   <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            mode_q   <= mode_d;
            bypass_q <= bypass_d;
            pair_q   <= pair_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            row_buf[buf_addr] <= buf_wdata;
        end
    end

    assign result_out   = result_q;
    assign result_valid = rv_q;
    assign done_signal  = done_q;
    assign busy         = (state_q != S_IDLE);

endmodule
